// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame and divider widths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W     = 16;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: holding register, status pulses and consumer ack.
interface uart_rx_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] uart_rx_data;
    logic                                uart_rx_avail;
    logic                                uart_rx_valid;
    logic                                uart_rx_frame_err;
    logic                                uart_rx_overrun;
    logic                                uart_rx_ack;

    modport master (
        output uart_rx_data, uart_rx_avail, uart_rx_valid,
        output uart_rx_frame_err, uart_rx_overrun,
        input  uart_rx_ack
    );

    modport slave (
        input  uart_rx_data, uart_rx_avail, uart_rx_valid,
        input  uart_rx_frame_err, uart_rx_overrun,
        output uart_rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the serial line (resets to idle-high) with falling-edge detect.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o    = sync_q[SYNC_STAGES-1];
    assign rx_fall_o = prev_q & ~rx_s_o;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling at (divider+1) clocks per bit, one-deep holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  uart_clk,
    input  logic                  uart_rst_n,
    input  logic                  uart_ser_rx,
    input  logic [UART_DIV_W-1:0] uart_divider,
    output logic                  uart_rx_busy,
    uart_rx_if.master             rx_bus
);

    uart_rx_state_e              state_q, state_d;
    logic [UART_DIV_W-1:0]       cnt_q, cnt_d;
    logic [2:0]                  bitcnt_q, bitcnt_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   data_q, data_d;
    logic                        avail_q, avail_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        ovr_q, ovr_d;
    logic                        byte_done;
    logic                        ack_hit;
    logic                        rx_s, rx_fall;
    logic [UART_DIV_W-1:0]       half_div;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i    (uart_clk),
        .rst_ni   (uart_rst_n),
        .rx_i     (uart_ser_rx),
        .rx_s_o   (rx_s),
        .rx_fall_o(rx_fall)
    );

    assign half_div = uart_divider >> 1;
    assign ack_hit  = rx_bus.uart_rx_ack & avail_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            // Hold off until the synchroniser has flushed its reset value and shows idle.
            ARM: begin
                if (cnt_q < UART_DIV_W'(SYNC_STAGES)) cnt_d = cnt_q + 16'd1;
                else if (rx_s)                         state_d = IDLE;
            end
            IDLE: begin
                if (rx_fall) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    // At one clock per bit the detected edge already is the start sample.
                    state_d  = (uart_divider == '0) ? DATA : START;
                end
            end
            START: begin
                if (cnt_q == half_div) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == uart_divider) begin
                    cnt_d             = '0;
                    shift_d[bitcnt_q] = rx_s;
                    bitcnt_d          = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(UART_DATA_BITS-1)) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == uart_divider) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ARM;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // A concurrent ack consumes the old byte, so the new one is not an overrun.
    always_comb begin
        data_d  = data_q;
        avail_d = avail_q;
        ovr_d   = ovr_q;
        valid_d = byte_done;
        if (byte_done) begin
            data_d  = shift_q;
            avail_d = 1'b1;
            ovr_d   = ack_hit ? 1'b0 : (avail_q | ovr_q);
        end else if (ack_hit) begin
            avail_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_q  <= ARM;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            avail_q  <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            avail_q  <= avail_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_bus.uart_rx_data      = data_q;
    assign rx_bus.uart_rx_avail     = avail_q;
    assign rx_bus.uart_rx_valid     = valid_q;
    assign rx_bus.uart_rx_frame_err = ferr_q;
    assign rx_bus.uart_rx_overrun   = ovr_q;
    assign uart_rx_busy             = (state_q != IDLE);

endmodule
